// File: rtl/risc16_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | risc16_mem_responder: unified word memory for the risc16ba core with a     |
// | byte-stream boot loader that holds the core in reset until loading ends.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module risc16_mem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iaddr,
  input  logic        ioe,
  output logic [15:0] idin,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic [15:0] ddin,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_start,
  output logic        cpu_rst,
  output logic        ld_done
);

  typedef enum logic [1:0] {
    HDR_HI = 2'd0,
    HDR_LO = 2'd1,
    DATA   = 2'd2,
    RUN    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ptr_q, ptr_d;
  logic        cpu_rst_q, cpu_rst_d;

  logic [15:0] mem_q [2**ADDR_WIDTH];

  logic                  w_accept;
  logic                  w_we_hi;
  logic                  w_we_lo;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [15:0]           w_wdata;
  logic                  w_unused;

  // Only the word-index bits of each address are decoded; the rest alias.
  assign w_unused = ^{iaddr, daddr};

  assign ld_ready = (state_q != RUN);
  assign ld_done  = (state_q == RUN);
  assign cpu_rst  = cpu_rst_q;
  assign w_accept = ld_valid & ld_ready;

  assign idin = ioe ? mem_q[iaddr[ADDR_WIDTH:1]] : 16'h0000;
  assign ddin = doe ? mem_q[daddr[ADDR_WIDTH:1]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR_HI;
      len_q     <= 16'h0000;
      ptr_q     <= 16'h0000;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    case (state_q)
      HDR_HI: begin
        if (w_accept) begin
          len_d   = {ld_data, len_q[7:0]};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (w_accept) begin
          len_d   = {len_q[15:8], ld_data};
          ptr_d   = 16'h0000;
          state_d = ({len_q[15:8], ld_data} == 16'h0000) ? RUN : DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          ptr_d = ptr_q + 16'd1;
          if ((ptr_q + 16'd1) == len_q) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_d = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase
    // Registered so the core sees reset drop exactly on the edge entering RUN.
    cpu_rst_d = (state_d != RUN);
  end

  // Loader and core never write together: loader writes only while cpu_rst is high.
  always_comb begin
    w_we_hi = 1'b0;
    w_we_lo = 1'b0;
    w_waddr = ptr_q[ADDR_WIDTH:1];
    w_wdata = {ld_data, ld_data};
    if (!cpu_rst_q) begin
      w_we_hi = dwe0;
      w_we_lo = dwe1;
      w_waddr = daddr[ADDR_WIDTH:1];
      w_wdata = ddout;
    end else if ((state_q == DATA) && w_accept && !rst) begin
      w_we_hi = ~ptr_q[0];
      w_we_lo = ptr_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_hi) begin
      mem_q[w_waddr][15:8] <= w_wdata[15:8];
    end
    if (w_we_lo) begin
      mem_q[w_waddr][7:0] <= w_wdata[7:0];
    end
  end

endmodule
`default_nettype wire
